nios_system_from_cpu_req: RTL



---
 rtl/nios_system_pio_pkg.sv | 22 ++
 rtl/nios_system_bit_sync.sv | 35 +++
 rtl/nios_system_from_cpu_req.sv | 157 +++++++++++++++
 3 files changed

// File: rtl/nios_system_pio_pkg.sv
// Shared definitions for the Nios PIO handshake blocks: register map,
// status bit positions and the request FSM encoding.
package nios_system_pio_pkg;

    localparam logic [1:0] ADDR_DATA    = 2'd0;
    localparam logic [1:0] ADDR_CTRL    = 2'd1;
    localparam logic [1:0] ADDR_TIMEOUT = 2'd2;
    localparam logic [1:0] ADDR_CLEAR   = 2'd3;

    localparam int BUSY  = 0;
    localparam int IRQEN = 1;
    localparam int DONE  = 2;
    localparam int TMO   = 3;
    localparam int OVR   = 4;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        REQ_HI = 2'd1,
        REQ_LO = 2'd2
    } req_state_t;

endpackage

// File: rtl/nios_system_bit_sync.sv
// Single-bit synchronizer with configurable depth; depth 0 passes the input
// straight through for sources already in the clk domain.
module nios_system_bit_sync #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic q
);

    generate
        if (STAGES == 0) begin : g_bypass
            logic unused_bypass;
            assign unused_bypass = clk ^ reset;
            assign q = d;
        end else begin : g_chain
            logic [STAGES-1:0] chain;

            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    chain <= '0;
                end else begin
                    chain[0] <= d;
                    for (int i = 1; i < STAGES; i++) begin
                        chain[i] <= chain[i-1];
                    end
                end
            end

            assign q = chain[STAGES-1];
        end
    endgenerate

endmodule

// File: rtl/nios_system_from_cpu_req.sv
// Avalon-MM slave that latches a CPU data word and presents it to fabric
// logic under a 4-phase req/ack handshake with optional timeout.
module nios_system_from_cpu_req
    import nios_system_pio_pkg::*;
#(
    parameter int DATA_W      = 8,
    parameter int TO_W        = 16,
    parameter int SYNC_STAGES = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [1:0]        address,
    input  logic              chipselect,
    input  logic              write_n,
    input  logic [31:0]       writedata,
    output logic [31:0]       readdata,
    output logic              irq,
    output logic [DATA_W-1:0] out_data,
    output logic              out_req,
    input  logic              ack_in
);

    req_state_t        state;
    req_state_t        state_next;
    logic [DATA_W-1:0] data_reg;
    logic [TO_W-1:0]   timeout_reg;
    logic [TO_W-1:0]   cnt;
    logic              irq_en;
    logic              done;
    logic              tmo;
    logic              ovr;
    logic              ack_s;

    logic wr;
    logic busy;
    logic go;
    logic clr;
    logic tmo_hit;
    logic start;
    logic done_set;
    logic tmo_set;
    logic ovr_set;
    logic unused_wdata;

    nios_system_bit_sync #(
        .STAGES (SYNC_STAGES)
    ) u_ack_sync (
        .clk   (clk),
        .reset (reset),
        .d     (ack_in),
        .q     (ack_s)
    );

    assign wr           = chipselect & ~write_n;
    assign busy         = (state != IDLE);
    assign go           = wr && (address == ADDR_CTRL) && writedata[0];
    assign clr          = wr && (address == ADDR_CLEAR);
    assign tmo_hit      = (timeout_reg != '0) && (cnt == timeout_reg - TO_W'(1));
    assign irq          = irq_en & done;
    assign unused_wdata = ^writedata;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // A handshake step in the same cycle as the timeout limit takes precedence.
    always_comb begin
        state_next = state;
        start      = 1'b0;
        done_set   = 1'b0;
        tmo_set    = 1'b0;
        ovr_set    = busy && ((wr && address == ADDR_DATA) || go);
        case (state)
            IDLE: begin
                if (go) begin
                    if (!ack_s) begin
                        start      = 1'b1;
                        state_next = REQ_HI;
                    end else begin
                        ovr_set = 1'b1;
                    end
                end
            end
            REQ_HI: begin
                if (ack_s) begin
                    state_next = REQ_LO;
                end else if (tmo_hit) begin
                    tmo_set    = 1'b1;
                    state_next = IDLE;
                end
            end
            REQ_LO: begin
                if (!ack_s) begin
                    done_set   = 1'b1;
                    state_next = IDLE;
                end else if (tmo_hit) begin
                    tmo_set    = 1'b1;
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Payload is shadowed from the pre-write DATA value, so a same-cycle DATA write only affects the next transfer.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_req     <= 1'b0;
            out_data    <= '0;
            cnt         <= '0;
            data_reg    <= '0;
            timeout_reg <= '0;
            irq_en      <= 1'b0;
            done        <= 1'b0;
            tmo         <= 1'b0;
            ovr         <= 1'b0;
        end else begin
            out_req <= (state_next == REQ_HI);
            if (start) begin
                out_data <= data_reg;
                cnt      <= '0;
            end else if (busy && cnt != '1) begin
                cnt <= cnt + TO_W'(1);
            end
            if (wr && address == ADDR_DATA && !busy) begin
                data_reg <= writedata[DATA_W-1:0];
            end
            if (wr && address == ADDR_TIMEOUT) begin
                timeout_reg <= writedata[TO_W-1:0];
            end
            if (wr && address == ADDR_CTRL) begin
                irq_en <= writedata[IRQEN];
            end
            done <= (done & ~(clr & writedata[DONE])) | done_set;
            tmo  <= (tmo  & ~(clr & writedata[TMO]))  | tmo_set;
            ovr  <= (ovr  & ~(clr & writedata[OVR]))  | ovr_set;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            readdata <= '0;
        end else begin
            case (address)
                ADDR_DATA:    readdata <= 32'(data_reg);
                ADDR_CTRL:    readdata <= {27'b0, ovr, tmo, done, irq_en, busy};
                ADDR_TIMEOUT: readdata <= 32'(timeout_reg);
                default:      readdata <= '0;
            endcase
        end
    end

endmodule
